// File: rtl/cmd_loader.sv
// Program store/loader: byte-stream header + LE words into word RAM, then serves cmd/cmd_en by cmd_id.
// Fetch is registered (cmd valid one rising edge after cmd_id); ld_ready drops while running, no loader buffering.
module cmd_loader #(
    parameter int DEPTH_LOG2 = 8
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic [7:0]  ld_data,
    input  logic        ld_valid,
    output logic        ld_ready,
    input  logic        run,
    input  logic [15:0] cmd_id,
    output logic [31:0] cmd,
    output logic        cmd_en,
    output logic        core_rst_n,
    output logic [15:0] prog_len,
    output logic        done,
    output logic        err
);

    localparam int          DEPTH   = 1 << DEPTH_LOG2;
    localparam logic [16:0] DEPTH_W = 17'(DEPTH);
    localparam logic [15:0] DEPTH_L = DEPTH_W[15:0];

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_DATA,
        S_READY,
        S_RUN,
        S_DONE
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] hdr_n_q, hdr_n_d;
    logic [15:0] word_idx_q, word_idx_d;
    logic [1:0]  byte_idx_q, byte_idx_d;
    logic [23:0] word_buf_q, word_buf_d;
    logic [31:0] cmd_q, cmd_d;
    logic        cmd_en_q, cmd_en_d;
    logic        core_rst_n_q, core_rst_n_d;
    logic [15:0] prog_len_q, prog_len_d;
    logic        done_q, done_d;
    logic        err_q, err_d;

    logic [31:0]           mem [DEPTH];
    logic                  mem_we;
    logic [DEPTH_LOG2-1:0] mem_waddr;
    logic [31:0]           mem_wdat;

    logic        ld_acc;
    logic [15:0] n_hdr;
    logic [15:0] len_clamp;

    assign ld_ready   = (state_q == S_IDLE) || (state_q == S_HDR) ||
                        (state_q == S_DATA) || (state_q == S_READY);
    assign ld_acc     = ld_valid && ld_ready;
    assign n_hdr      = {ld_data, hdr_n_q[7:0]};
    assign len_clamp  = ({1'b0, hdr_n_q} > DEPTH_W) ? DEPTH_L : hdr_n_q;

    assign cmd        = cmd_q;
    assign cmd_en     = cmd_en_q;
    assign core_rst_n = core_rst_n_q;
    assign prog_len   = prog_len_q;
    assign done       = done_q;
    assign err        = err_q;

    always_comb begin
        state_d    = state_q;
        hdr_n_d    = hdr_n_q;
        word_idx_d = word_idx_q;
        byte_idx_d = byte_idx_q;
        word_buf_d = word_buf_q;
        cmd_d      = cmd_q;
        cmd_en_d   = cmd_en_q;
        prog_len_d = prog_len_q;
        done_d     = done_q;
        err_d      = err_q;
        mem_we     = 1'b0;
        mem_waddr  = word_idx_q[DEPTH_LOG2-1:0];
        mem_wdat   = {ld_data, word_buf_q};

        unique case (state_q)
            S_IDLE, S_READY: begin
                // A new header takes priority over starting a run
                if (ld_acc) begin
                    hdr_n_d    = {8'h00, ld_data};
                    err_d      = 1'b0;
                    prog_len_d = 16'd0;
                    state_d    = S_HDR;
                end else if ((state_q == S_READY) && run) begin
                    state_d  = S_RUN;
                    cmd_en_d = 1'b1;
                    cmd_d    = mem[0];
                end
            end
            S_HDR: begin
                if (ld_acc) begin
                    hdr_n_d    = n_hdr;
                    word_idx_d = 16'd0;
                    byte_idx_d = 2'd0;
                    if (n_hdr == 16'd0) begin
                        state_d    = S_READY;
                        prog_len_d = 16'd0;
                    end else begin
                        state_d = S_DATA;
                        if ({1'b0, n_hdr} > DEPTH_W) begin
                            err_d = 1'b1;
                        end
                    end
                end
            end
            S_DATA: begin
                if (ld_acc) begin
                    byte_idx_d = byte_idx_q + 2'd1;
                    case (byte_idx_q)
                        2'd0:    word_buf_d[7:0]   = ld_data;
                        2'd1:    word_buf_d[15:8]  = ld_data;
                        2'd2:    word_buf_d[23:16] = ld_data;
                        default: begin
                            // Words past the RAM depth are consumed but dropped
                            mem_we     = ({1'b0, word_idx_q} < DEPTH_W);
                            word_idx_d = word_idx_q + 16'd1;
                            if (word_idx_q == (hdr_n_q - 16'd1)) begin
                                state_d    = S_READY;
                                prog_len_d = len_clamp;
                            end
                        end
                    endcase
                end
            end
            S_RUN: begin
                if (!run) begin
                    state_d  = S_READY;
                    cmd_en_d = 1'b0;
                end else if (cmd_id >= prog_len_q) begin
                    state_d  = S_DONE;
                    cmd_en_d = 1'b0;
                    done_d   = 1'b1;
                end else begin
                    cmd_d    = mem[cmd_id[DEPTH_LOG2-1:0]];
                    cmd_en_d = 1'b1;
                end
            end
            S_DONE: begin
                if (!run) begin
                    state_d = S_READY;
                    done_d  = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase

        core_rst_n_d = (state_d == S_RUN) || (state_d == S_DONE);
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q      <= S_IDLE;
            hdr_n_q      <= 16'd0;
            word_idx_q   <= 16'd0;
            byte_idx_q   <= 2'd0;
            word_buf_q   <= 24'd0;
            cmd_q        <= 32'd0;
            cmd_en_q     <= 1'b0;
            core_rst_n_q <= 1'b0;
            prog_len_q   <= 16'd0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            hdr_n_q      <= hdr_n_d;
            word_idx_q   <= word_idx_d;
            byte_idx_q   <= byte_idx_d;
            word_buf_q   <= word_buf_d;
            cmd_q        <= cmd_d;
            cmd_en_q     <= cmd_en_d;
            core_rst_n_q <= core_rst_n_d;
            prog_len_q   <= prog_len_d;
            done_q       <= done_d;
            err_q        <= err_d;
        end
    end

    // Program RAM is deliberately not reset so it survives aborts and resets
    always_ff @(posedge sys_clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdat;
        end
    end

endmodule

// File: tb/tb_cmd_loader.sv
// Bench for cmd_loader: queue-based reference model checked every cycle, plus directed literal checks.
module tb_cmd_loader;

    localparam int DL2   = 2;
    localparam int DEPTH = 4;

    localparam int M_IDLE  = 0;
    localparam int M_LOAD  = 1;
    localparam int M_READY = 2;
    localparam int M_RUN   = 3;
    localparam int M_DONE  = 4;

    logic        sys_clk   = 1'b0;
    logic        sys_rst_n = 1'b0;
    logic [7:0]  ld_data   = 8'h00;
    logic        ld_valid  = 1'b0;
    logic        ld_ready;
    logic        run       = 1'b0;
    logic [15:0] cmd_id;
    logic [31:0] cmd;
    logic        cmd_en;
    logic        core_rst_n;
    logic [15:0] prog_len;
    logic        done;
    logic        err;

    int total = 0;
    int bad   = 0;

    cmd_loader #(.DEPTH_LOG2(DL2)) dut (
        .sys_clk    (sys_clk),
        .sys_rst_n  (sys_rst_n),
        .ld_data    (ld_data),
        .ld_valid   (ld_valid),
        .ld_ready   (ld_ready),
        .run        (run),
        .cmd_id     (cmd_id),
        .cmd        (cmd),
        .cmd_en     (cmd_en),
        .core_rst_n (core_rst_n),
        .prog_len   (prog_len),
        .done       (done),
        .err        (err)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Core: held at command 0 in reset, executes one command per falling edge while cmd_en
    always @(negedge sys_clk or negedge core_rst_n) begin
        if (!core_rst_n) cmd_id = 16'd0;
        else if (cmd_en) cmd_id = cmd_id + 16'd1;
    end

    // Reference model: the load is a byte list; words are decoded from it as they complete
    int           m_mode;
    byte unsigned q[$];
    logic [31:0]  m_mem [DEPTH];
    bit           m_vld [DEPTH];
    int           m_len;
    int           m_n;
    bit           m_err;
    logic [31:0]  e_cmd;
    bit           e_known;
    bit           e_en, e_crst, e_done;

    always @(posedge sys_clk or negedge sys_rst_n) begin
        int s, w;
        bit acc;
        if (!sys_rst_n) begin
            m_mode = M_IDLE; q.delete(); m_len = 0; m_err = 0;
            e_cmd = 0; e_known = 0; e_en = 0; e_crst = 0; e_done = 0;
        end else begin
            acc = ld_valid && (m_mode <= M_READY);
            case (m_mode)
                M_IDLE, M_READY: begin
                    if (acc) begin
                        q.delete(); q.push_back(ld_data);
                        m_err = 0; m_len = 0; m_mode = M_LOAD;
                    end else if (m_mode == M_READY && run) begin
                        m_mode = M_RUN; e_en = 1; e_crst = 1;
                        e_cmd = m_mem[0]; e_known = m_vld[0];
                    end
                end
                M_LOAD: begin
                    if (acc) begin
                        q.push_back(ld_data);
                        s = q.size();
                        if (s == 2) begin
                            m_n = int'(q[0]) + 256 * int'(q[1]);
                            if (m_n == 0) begin m_mode = M_READY; m_len = 0; end
                            if (m_n > DEPTH) m_err = 1;
                        end else if ((s - 2) % 4 == 0) begin
                            w = (s - 2) / 4 - 1;
                            if (w < DEPTH) begin
                                m_mem[w] = {q[s-1], q[s-2], q[s-3], q[s-4]};
                                m_vld[w] = 1;
                            end
                            if (w + 1 == m_n) begin
                                m_mode = M_READY;
                                m_len = (m_n < DEPTH) ? m_n : DEPTH;
                            end
                        end
                    end
                end
                M_RUN: begin
                    if (!run) begin
                        m_mode = M_READY; e_en = 0; e_crst = 0;
                    end else if (int'(cmd_id) >= m_len) begin
                        m_mode = M_DONE; e_en = 0; e_done = 1;
                    end else begin
                        e_cmd = m_mem[int'(cmd_id) % DEPTH];
                        e_known = m_vld[int'(cmd_id) % DEPTH];
                        e_en = 1;
                    end
                end
                default: begin
                    if (!run) begin m_mode = M_READY; e_done = 0; e_crst = 0; end
                end
            endcase
        end
    end

    logic [31:0] cmd_log[$];

    always @(posedge sys_clk) begin
        #1;
        if (sys_rst_n) begin
            check("ld_ready",   32'(ld_ready),   32'(m_mode <= M_READY));
            check("cmd_en",     32'(cmd_en),     32'(e_en));
            check("core_rst_n", 32'(core_rst_n), 32'(e_crst));
            check("done",       32'(done),       32'(e_done));
            check("err",        32'(err),        32'(m_err));
            check("prog_len",   32'(prog_len),   32'(m_len));
            if (e_en && e_known) check("cmd", cmd, e_cmd);
            if (cmd_en) cmd_log.push_back(cmd);
        end
    end

    task automatic send_byte(input logic [7:0] b, input int gap);
        repeat (gap) @(negedge sys_clk);
        ld_valid = 1'b1;
        ld_data  = b;
        @(negedge sys_clk);
        ld_valid = 1'b0;
    endtask

    task automatic load_prog(input int n, input logic [31:0] words[$], input int gmax);
        logic [31:0] wv;
        send_byte(8'(n), $urandom_range(0, gmax));
        send_byte(8'(n >> 8), $urandom_range(0, gmax));
        foreach (words[i]) begin
            wv = words[i];
            for (int b = 0; b < 4; b++) send_byte(wv[8*b +: 8], $urandom_range(0, gmax));
        end
    endtask

    // Raises run and waits (bounded) for done; leaves run high
    task automatic run_to_done(input string name, input int budget);
        bit fin = 0;
        @(negedge sys_clk);
        run = 1'b1;
        for (int i = 0; i < budget; i++) begin
            @(negedge sys_clk);
            if (done) begin fin = 1; break; end
        end
        check({name, "_reached_done"}, 32'(fin), 32'd1);
    endtask

    task automatic stop_run();
        @(negedge sys_clk);
        run = 1'b0;
        repeat (2) @(negedge sys_clk);
    endtask

    task automatic check_log(input string name, input logic [31:0] exp[$]);
        check({name, "_count"}, 32'(cmd_log.size()), 32'(exp.size()));
        foreach (exp[i]) check({name, "_cmd"}, (cmd_log.size() > i) ? cmd_log[i] : 32'hdead_beef, exp[i]);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] w3[$];
        logic [31:0] w6[$];
        logic [31:0] w2[$];
        logic [31:0] wr[$];
        logic [31:0] none[$];
        logic [31:0] exp[$];
        int n;

        repeat (3) @(negedge sys_clk);
        sys_rst_n = 1'b1;
        @(negedge sys_clk);
        check("rst_ld_ready",   32'(ld_ready),   32'd1);
        check("rst_cmd_en",     32'(cmd_en),     32'd0);
        check("rst_core_rst_n", 32'(core_rst_n), 32'd0);
        check("rst_prog_len",   32'(prog_len),   32'd0);
        check("rst_err",        32'(err),        32'd0);
        check("rst_done",       32'(done),       32'd0);

        // Normal three-word program
        w3 = '{32'h0000_0102, 32'h0000_0003, 32'h0000_0000};
        load_prog(3, w3, 0);
        check("norm_prog_len", 32'(prog_len), 32'd3);
        cmd_log.delete();
        run_to_done("norm", 40);
        check_log("norm", w3);
        check("norm_done", 32'(done), 32'd1);
        check("norm_core_rst_n", 32'(core_rst_n), 32'd1);
        stop_run();
        check("norm_stop_done", 32'(done), 32'd0);
        check("norm_stop_crst", 32'(core_rst_n), 32'd0);

        // Empty program: one RUN cycle with cmd_en, then DONE
        load_prog(0, none, 0);
        check("empty_prog_len", 32'(prog_len), 32'd0);
        cmd_log.delete();
        run_to_done("empty", 10);
        check("empty_en_cycles", 32'(cmd_log.size()), 32'd1);
        stop_run();

        // Oversize: six words into four-word RAM
        w6 = '{32'h1111_0001, 32'h2222_0002, 32'h3333_0003,
               32'h4444_0004, 32'h5555_0005, 32'h6666_0006};
        load_prog(6, w6, 1);
        check("over_err", 32'(err), 32'd1);
        check("over_prog_len", 32'(prog_len), 32'd4);
        cmd_log.delete();
        run_to_done("over", 40);
        exp = '{32'h1111_0001, 32'h2222_0002, 32'h3333_0003, 32'h4444_0004};
        check_log("over", exp);
        stop_run();

        // Abort at cmd_id 1, then restart from command 0
        @(negedge sys_clk);
        run = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge sys_clk);
            #1;
            if (cmd_id == 16'd1) break;
        end
        run = 1'b0;
        @(posedge sys_clk);
        #1;
        check("abort_cmd_en", 32'(cmd_en), 32'd0);
        check("abort_core_rst_n", 32'(core_rst_n), 32'd0);
        @(negedge sys_clk);
        run = 1'b1;
        @(posedge sys_clk);
        #1;
        check("restart_cmd", cmd, 32'h1111_0001);
        check("restart_cmd_en", 32'(cmd_en), 32'd1);
        for (int i = 0; i < 20; i++) begin
            @(negedge sys_clk);
            if (done) break;
        end
        check("restart_done", 32'(done), 32'd1);
        stop_run();

        // New header clears err; reset after 5 of 10 bytes
        send_byte(8'h02, 0);
        check("hdr_clears_err", 32'(err), 32'd0);
        send_byte(8'h00, 0);
        send_byte(8'hAA, 0);
        send_byte(8'hBB, 0);
        send_byte(8'hCC, 0);
        sys_rst_n = 1'b0;
        repeat (2) @(negedge sys_clk);
        check("midrst_ld_ready", 32'(ld_ready), 32'd1);
        check("midrst_prog_len", 32'(prog_len), 32'd0);
        sys_rst_n = 1'b1;
        @(negedge sys_clk);
        w2 = '{32'hCAFE_F00D, 32'h0BAD_BEEF};
        load_prog(2, w2, 4);
        check("reload_prog_len", 32'(prog_len), 32'd2);
        cmd_log.delete();
        run_to_done("reload", 20);
        check_log("reload", w2);
        stop_run();

        // Random programs, gaps and abort points against the model
        for (int it = 0; it < 25; it++) begin
            n = $urandom_range(0, 6);
            wr.delete();
            for (int k = 0; k < n; k++) wr.push_back($urandom);
            load_prog(n, wr, $urandom_range(0, 3));
            check("rand_prog_len", 32'(prog_len), 32'((n < DEPTH) ? n : DEPTH));
            check("rand_err", 32'(err), 32'(n > DEPTH));
            @(negedge sys_clk);
            run = 1'b1;
            repeat ($urandom_range(1, 10)) @(negedge sys_clk);
            stop_run();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
